// File: rtl/pnc_stmc_pkg.sv
// Shared word-format constants for the spike packer and the STMC control unit.
package pnc_stmc_pkg;

  localparam int WORD_W    = 16;
  localparam int PAR_W     = 15;
  localparam int ADDR_W    = 7;
  localparam int PARAM_BIT = 15;
  localparam int RC_BIT    = 14;
  localparam int ADDR2_MSB = 13;
  localparam int ADDR2_LSB = 7;
  localparam int ADDR1_MSB = 6;
  localparam int ADDR1_LSB = 0;

  localparam logic [ADDR_W-1:0] NULL_ADDR = '0;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } pk_state_e;

  function automatic logic [WORD_W-1:0] pack_param(input logic [PAR_W-1:0] payload);
    logic [WORD_W-1:0] w;
    w            = '0;
    w[PARAM_BIT] = 1'b1;
    w[PAR_W-1:0] = payload;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] pack_rc(input logic [ADDR_W-1:0] addr);
    logic [WORD_W-1:0] w;
    w                      = '0;
    w[RC_BIT]              = 1'b1;
    w[ADDR1_MSB:ADDR1_LSB] = addr;
    return w;
  endfunction

  // A lone spike is a pair whose second address is the null address.
  function automatic logic [WORD_W-1:0] pack_pair(input logic [ADDR_W-1:0] first,
                                                  input logic [ADDR_W-1:0] second);
    logic [WORD_W-1:0] w;
    w                      = '0;
    w[ADDR2_MSB:ADDR2_LSB] = second;
    w[ADDR1_MSB:ADDR1_LSB] = first;
    return w;
  endfunction

endpackage

// File: rtl/pnc_stmc_spike_packer.sv
// Packs spike events and parameter words into 16-bit STMC words, pairing
// consecutive normal spikes and sending a lone spike after TIMEOUT cycles.
module pnc_stmc_spike_packer
  import pnc_stmc_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_spk_valid,
  input  logic [ADDR_W-1:0] i_spk_addr,
  input  logic              i_spk_rc,
  output logic              i_spk_ready,
  input  logic              i_par_valid,
  input  logic [PAR_W-1:0]  i_par_data,
  output logic              i_par_ready,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_addr,
  input  logic              o_ready
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  pk_state_e         r_state;
  logic [ADDR_W-1:0] r_held;
  logic [TW-1:0]     r_timer;
  logic              r_valid;
  logic [WORD_W-1:0] r_word;

  logic w_out_free;
  logic w_leave;
  logic w_spk_acc;
  logic w_par_acc;
  logic w_spk_norm;

  // NOTE: the ready outputs are combinational so a handshake completes in the
  // same cycle it is offered; every signal gets a default to avoid latches.
  always_comb begin
    w_out_free  = !r_valid || o_ready;
    w_leave     = 1'b0;
    i_spk_ready = 1'b0;
    i_par_ready = 1'b0;
    if (!rst && w_out_free) begin
      if (r_state == ST_IDLE) begin
        i_par_ready = 1'b1;
        i_spk_ready = !i_par_valid;
      end else begin
        w_leave     = i_flush || (r_timer == T_LAST) || i_par_valid ||
                      (i_spk_valid && i_spk_rc);
        i_spk_ready = !w_leave;
      end
    end
    w_spk_acc  = i_spk_valid && i_spk_ready;
    w_par_acc  = i_par_valid && i_par_ready;
    w_spk_norm = w_spk_acc && !i_spk_rc && (i_spk_addr != NULL_ADDR);
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_held  <= NULL_ADDR;
      r_timer <= '0;
      r_valid <= 1'b0;
      r_word  <= '0;
    end else begin
      if (w_out_free) r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_par_acc) begin
            r_valid <= 1'b1;
            r_word  <= pack_param(i_par_data);
          end else if (w_spk_acc && i_spk_rc) begin
            r_valid <= 1'b1;
            r_word  <= pack_rc(i_spk_addr);
          end else if (w_spk_norm) begin
            r_held  <= i_spk_addr;
            r_timer <= '0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_leave) begin
            r_valid <= 1'b1;
            r_word  <= pack_pair(r_held, NULL_ADDR);
            r_held  <= NULL_ADDR;
            r_state <= ST_IDLE;
          end else begin
            if (r_timer != T_LAST) r_timer <= r_timer + TW'(1);
            if (w_spk_norm) begin
              r_valid <= 1'b1;
              r_word  <= pack_pair(r_held, i_spk_addr);
              r_held  <= NULL_ADDR;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_word;

endmodule
